seven_segment_scan_decoder: RTL and testbench
=============================================

// Module: seven_segment_scan_decoder
// PURPOSE
//  Receive-side counterpart of the 4-digit multiplexed 7-segment display controller.
//  Samples the scanned anode/cathode lines and rebuilds the displayed 4-digit BCD value and its binary equivalent.
//  Flags malformed scans and reports a stale display.
//  Sits on the board-test path: loops the display outputs back and compares them against the pattern count.
// PARAMETERS
//  SETTLE_CYCLES   16       anode+cathode must be unchanged this many cycles before a digit is captured
//  TIMEOUT_CYCLES  1048576  cycles without a good frame before stale asserts (~2 refresh periods)
// PORTS
//  clock_100Mhz   in   1   single clock for all logic
//  reset          in   1   synchronous, active-high
//  anode_in       in   4   active-low digit select; [3]=leftmost digit (digit0) ... [0]=digit3
//  cathode_in     in   7   active-low segments {a,b,c,d,e,f,g}; "0"=7'b0000001, "1"=7'b1001111
//  digits_out     out  16  captured BCD {digit0,digit1,digit2,digit3}
//  binary_out     out  14  digit0*1000 + digit1*100 + digit2*10 + digit3 (0..9999)
//  frame_valid    out  1   one-cycle pulse: new good frame loaded into digits_out/binary_out
//  error_flag     out  1   one-cycle pulse: frame aborted (bad segment pattern, non-one-hot anode, out-of-order digit)
//  stale          out  1   level: no good frame for TIMEOUT_CYCLES
//  capture_mask   out  4   digits captured so far in the current frame; bit i = digit i
// BEHAVIOUR
//  Reset: all outputs 0; partial frame, stability counter and timeout counter cleared. A mid-frame reset discards the frame.
//  Inputs are registered once (in_q). stab_cnt:
//    - clears when {anode,cathode} differs from in_q;
//    - otherwise increments, saturating at SETTLE_CYCLES.
//  Capture event: fires the cycle stab_cnt first reaches SETTLE_CYCLES-1, i.e. once per dwell.
//    - anode 4'b1111 (blank): ignored, no event.
//    - anode with more than one bit low: protocol error.
//    - one-hot anode: decoded to digit index 0..3.
//  Segment decode: the ten legal patterns map to 0..9. Any other pattern is invalid (value 4'hF, bad bit set).
//  FSM
//    IDLE    : wait for a digit0 capture; load slot0; mask=0001; go COLLECT.
//    COLLECT : expect index = last+1.
//      - Match: load slot, set mask bit.
//      - Index 3 loaded: go DONE.
//      - Wrong index or protocol error: error_flag pulse, mask=0.
//          Offending index 0 -> restart COLLECT with slot0; otherwise -> IDLE.
//    DONE (1 cycle): mask=0, go IDLE.
//      - No bad bit: digits_out/binary_out update, frame_valid=1.
//      - Any bad bit: error_flag=1, outputs hold.
//  Latency: digit3 capture at cycle T -> frame_valid/error_flag and new outputs at T+1. Pulses never overlap.
//  binary_out: computed from slots with shift-add (x1000=x<<10-x<<4-x<<3, etc.), 14-bit result, registered in DONE.
//  Timeout counter: clears on frame_valid, else increments saturating; stale = (cnt >= TIMEOUT_CYCLES).
//    If a frame completes in the same cycle the threshold is reached, frame_valid wins: counter clears, stale stays 0.
//  A repeated identical frame still pulses frame_valid each scan.
// STRUCTURE
//  Shared include seg7_defs.vh:
//    - SEG_0..SEG_9 cathode constants (shared with the display controller);
//    - ANODE_DIG0..ANODE_DIG3 = 4'b0111, 4'b1011, 4'b1101, 4'b1110;
//    - FSM state encodings.
//  Sub-module seg7_pattern_decode: combinational 7-bit pattern -> {valid, bcd[3:0]}; instantiated once.
// TESTING (sim: SETTLE_CYCLES=4, TIMEOUT_CYCLES=64; each digit held 8 cycles unless stated)
//  1. Scan 1,2,3,4 on digits 0..3 -> one frame_valid; digits_out=16'h1234, binary_out=1234; scan 9,9,9,9 -> binary_out=9999.
//  2. Digit2 cathode=7'b1111111 in next frame -> error_flag pulse at T+1, no frame_valid; digits_out stays 16'h1234.
//  3. Digit1 cathode glitches at dwell cycle 2, then stable 6 cycles -> captured only after 4 stable cycles; frame_valid, one capture per dwell.
//  4. Anode sequence 0111,1101 -> error_flag after 2nd capture, capture_mask=0. Anode 1001 -> error_flag.
//  5. No scan for 64 cycles -> stale=1; next good frame -> frame_valid and stale=0 the cycle after.
//  6. Reset held one cycle after digit1 capture -> capture_mask=0, all outputs 0; remaining digits 2,3 produce no frame_valid.

Source files
------------

// File: rtl/seven_segment_scan_decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seven_segment_scan_decoder_pkg
// Purpose  : Shared constants for the 7-segment scan decoder. Contains the
//            active-low cathode patterns for digits 0..9, the active-low
//            anode selects for each digit position, the FSM state encoding
//            and a BCD-to-binary helper that uses only shifts and adds.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package seven_segment_scan_decoder_pkg;

  // Active-low segment patterns {a,b,c,d,e,f,g}. These are the same
  // patterns the display controller drives.
  localparam logic [6:0] SEG_0 = 7'b0000001;
  localparam logic [6:0] SEG_1 = 7'b1001111;
  localparam logic [6:0] SEG_2 = 7'b0010010;
  localparam logic [6:0] SEG_3 = 7'b0000110;
  localparam logic [6:0] SEG_4 = 7'b1001100;
  localparam logic [6:0] SEG_5 = 7'b0100100;
  localparam logic [6:0] SEG_6 = 7'b0100000;
  localparam logic [6:0] SEG_7 = 7'b0001111;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0000100;

  // Active-low digit selects. Digit0 is the leftmost (most significant) digit.
  localparam logic [3:0] ANODE_DIG0  = 4'b0111;
  localparam logic [3:0] ANODE_DIG1  = 4'b1011;
  localparam logic [3:0] ANODE_DIG2  = 4'b1101;
  localparam logic [3:0] ANODE_DIG3  = 4'b1110;
  localparam logic [3:0] ANODE_BLANK = 4'b1111;

  // Frame assembly FSM states.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DONE    = 2'd2
  } scan_state_t;

  // {d0,d1,d2,d3} BCD -> d0*1000 + d1*100 + d2*10 + d3, built from shifts
  // and adds only:
  //   x*1000 = (x<<10) - (x<<4) - (x<<3)
  //   x*100  = (x<<6)  + (x<<5) + (x<<2)
  //   x*10   = (x<<3)  + (x<<1)
  // The 14-bit result holds 0..9999 for legal BCD inputs.
  function automatic logic [13:0] bcd4_to_bin(input logic [15:0] bcd);
    logic [13:0] d0;
    logic [13:0] d1;
    logic [13:0] d2;
    logic [13:0] d3;
    d0 = {10'd0, bcd[15:12]};
    d1 = {10'd0, bcd[11:8]};
    d2 = {10'd0, bcd[7:4]};
    d3 = {10'd0, bcd[3:0]};
    return ((d0 << 10) - (d0 << 4) - (d0 << 3))
         + ((d1 << 6) + (d1 << 5) + (d1 << 2))
         + ((d2 << 3) + (d2 << 1))
         + d3;
  endfunction

endpackage : seven_segment_scan_decoder_pkg
`default_nettype wire

// File: rtl/seven_segment_scan_decoder_pattern_decode.sv
`default_nettype none
// ============================================================================
// Module   : seg7_pattern_decode
// Purpose  : Combinational decode of one active-low 7-segment pattern into
//            its BCD value. Only the ten legal digit patterns are accepted;
//            anything else reports invalid and returns 4'hF.
// Ports    : i_pattern [6:0] - active-low segments {a,b,c,d,e,f,g}
//            o_valid         - 1 when i_pattern is one of SEG_0..SEG_9
//            o_bcd     [3:0] - decoded digit, 4'hF when invalid
// Revision : 1.0 - initial release
// ============================================================================
module seg7_pattern_decode
  import seven_segment_scan_decoder_pkg::*;
(
  input  logic [6:0] i_pattern,
  output logic       o_valid,
  output logic [3:0] o_bcd
);

  always_comb begin
    o_valid = 1'b1;
    o_bcd   = 4'hF;
    case (i_pattern)
      SEG_0:   o_bcd = 4'd0;
      SEG_1:   o_bcd = 4'd1;
      SEG_2:   o_bcd = 4'd2;
      SEG_3:   o_bcd = 4'd3;
      SEG_4:   o_bcd = 4'd4;
      SEG_5:   o_bcd = 4'd5;
      SEG_6:   o_bcd = 4'd6;
      SEG_7:   o_bcd = 4'd7;
      SEG_8:   o_bcd = 4'd8;
      SEG_9:   o_bcd = 4'd9;
      default: o_valid = 1'b0;
    endcase
  end

endmodule : seg7_pattern_decode
`default_nettype wire

// File: rtl/seven_segment_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module   : seven_segment_scan_decoder
// Purpose  : Receive side of a 4-digit multiplexed 7-segment display.
//            Samples the scanned anode/cathode lines, waits for each digit
//            to settle, reassembles the 4-digit BCD frame and its binary
//            value, flags malformed scans and reports a stale display.
// Ports    : clock_100Mhz        - single clock
//            reset               - synchronous, active-high
//            anode_in      [3:0] - active-low digit select, [3] = digit0
//            cathode_in    [6:0] - active-low segments {a..g}
//            digits_out   [15:0] - last good frame {digit0..digit3} in BCD
//            binary_out   [13:0] - last good frame as binary (0..9999)
//            frame_valid         - 1-cycle pulse, new good frame loaded
//            error_flag          - 1-cycle pulse, frame aborted
//            stale               - level, no good frame for TIMEOUT_CYCLES
//            capture_mask  [3:0] - digits captured in current frame
// Revision : 1.0 - initial release
// ============================================================================
module seven_segment_scan_decoder
  import seven_segment_scan_decoder_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 1048576
)(
  input  logic        clock_100Mhz,
  input  logic        reset,
  input  logic [3:0]  anode_in,
  input  logic [6:0]  cathode_in,
  output logic [15:0] digits_out,
  output logic [13:0] binary_out,
  output logic        frame_valid,
  output logic        error_flag,
  output logic        stale,
  output logic [3:0]  capture_mask
);

  localparam int c_stab_w = $clog2(SETTLE_CYCLES + 1);
  localparam int c_to_w   = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [c_stab_w-1:0] c_stab_max = c_stab_w'(SETTLE_CYCLES);
  localparam logic [c_stab_w-1:0] c_stab_hit = c_stab_w'(SETTLE_CYCLES - 1);
  localparam logic [c_to_w-1:0]   c_to_max   = c_to_w'(TIMEOUT_CYCLES);

  // --------------------------------------------------------------------------
  // Input register and settle counter
  // --------------------------------------------------------------------------
  logic [3:0]          r_anode_q;
  logic [6:0]          r_cath_q;
  logic [c_stab_w-1:0] r_stab_cnt;
  logic                w_changed;

  assign w_changed = ({anode_in, cathode_in} != {r_anode_q, r_cath_q});

  always_ff @(posedge clock_100Mhz) begin
    if (reset) begin
      r_anode_q  <= ANODE_BLANK;
      r_cath_q   <= 7'h7F;
      r_stab_cnt <= '0;
    end else begin
      r_anode_q <= anode_in;
      r_cath_q  <= cathode_in;
      if (w_changed) begin
        r_stab_cnt <= '0;
      end else if (r_stab_cnt != c_stab_max) begin
        r_stab_cnt <= r_stab_cnt + 1'b1;
      end
    end
  end

  // The counter passes through c_stab_hit exactly once per dwell before
  // saturating, so this is a single-cycle capture strobe per digit.
  logic w_settled;
  assign w_settled = (r_stab_cnt == c_stab_hit);

  // --------------------------------------------------------------------------
  // Anode classification
  // --------------------------------------------------------------------------
  logic [1:0] w_cap_idx;
  logic       w_one_hot;
  logic       w_blank;
  logic       w_cap_digit;
  logic       w_cap_proto;

  always_comb begin
    w_cap_idx = 2'd0;
    w_one_hot = 1'b1;
    case (r_anode_q)
      ANODE_DIG0: w_cap_idx = 2'd0;
      ANODE_DIG1: w_cap_idx = 2'd1;
      ANODE_DIG2: w_cap_idx = 2'd2;
      ANODE_DIG3: w_cap_idx = 2'd3;
      default:    w_one_hot = 1'b0;
    endcase
  end

  assign w_blank     = (r_anode_q == ANODE_BLANK);
  assign w_cap_digit = w_settled & w_one_hot;
  assign w_cap_proto = w_settled & ~w_one_hot & ~w_blank;

  // --------------------------------------------------------------------------
  // Segment decode
  // --------------------------------------------------------------------------
  logic       w_seg_valid;
  logic [3:0] w_seg_bcd;

  seg7_pattern_decode u_pattern_decode (
    .i_pattern (r_cath_q),
    .o_valid   (w_seg_valid),
    .o_bcd     (w_seg_bcd)
  );

  // --------------------------------------------------------------------------
  // Frame assembly
  // --------------------------------------------------------------------------
  scan_state_t r_state;
  logic [11:0] r_slots;      // {digit0, digit1, digit2}
  logic [2:0]  r_bad;        // bit i: slot i held an illegal pattern
  logic [1:0]  r_last_idx;

  logic        w_in_order;
  logic        w_frame_done;
  logic        w_frame_bad;
  logic        w_good_frame;
  logic [15:0] w_frame;

  // Digit3 is never stored: the frame is closed in the same cycle it is
  // captured, using the live decoder output as the last nibble.
  assign w_frame      = {r_slots, w_seg_bcd};
  assign w_in_order   = (w_cap_idx == r_last_idx + 2'd1);
  assign w_frame_done = (r_state == ST_COLLECT) & w_cap_digit & w_in_order
                      & (w_cap_idx == 2'd3);
  assign w_frame_bad  = (|r_bad) | ~w_seg_valid;
  assign w_good_frame = w_frame_done & ~w_frame_bad;

  // Results are loaded on entry to DONE so they are visible during the DONE
  // cycle, one cycle after the digit3 capture strobe.
  always_ff @(posedge clock_100Mhz) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_slots      <= '0;
      r_bad        <= '0;
      r_last_idx   <= 2'd0;
      capture_mask <= 4'b0000;
      digits_out   <= '0;
      binary_out   <= '0;
      frame_valid  <= 1'b0;
      error_flag   <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      error_flag  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // Anything other than a digit0 capture is ignored until a frame
          // has started.
          if (w_cap_digit && (w_cap_idx == 2'd0)) begin
            r_slots[11:8] <= w_seg_bcd;
            r_bad         <= {2'b00, ~w_seg_valid};
            capture_mask  <= 4'b0001;
            r_last_idx    <= 2'd0;
            r_state       <= ST_COLLECT;
          end
        end

        ST_COLLECT: begin
          if (w_cap_proto) begin
            error_flag   <= 1'b1;
            capture_mask <= 4'b0000;
            r_state      <= ST_IDLE;
          end else if (w_cap_digit) begin
            if (w_in_order) begin
              capture_mask[w_cap_idx] <= 1'b1;
              r_last_idx              <= w_cap_idx;
              case (w_cap_idx)
                2'd1: begin
                  r_slots[7:4] <= w_seg_bcd;
                  r_bad[1]     <= ~w_seg_valid;
                end
                2'd2: begin
                  r_slots[3:0] <= w_seg_bcd;
                  r_bad[2]     <= ~w_seg_valid;
                end
                default: begin
                  // Only index 3 reaches here: last_idx is never 3 in COLLECT.
                  r_state <= ST_DONE;
                  if (w_frame_bad) begin
                    error_flag <= 1'b1;
                  end else begin
                    frame_valid <= 1'b1;
                    digits_out  <= w_frame;
                    binary_out  <= bcd4_to_bin(w_frame);
                  end
                end
              endcase
            end else if (w_cap_idx == 2'd0) begin
              // A digit0 out of sequence is taken as the start of a new frame.
              error_flag    <= 1'b1;
              r_slots[11:8] <= w_seg_bcd;
              r_bad         <= {2'b00, ~w_seg_valid};
              capture_mask  <= 4'b0001;
              r_last_idx    <= 2'd0;
            end else begin
              error_flag   <= 1'b1;
              capture_mask <= 4'b0000;
              r_state      <= ST_IDLE;
            end
          end
        end

        ST_DONE: begin
          capture_mask <= 4'b0000;
          r_state      <= ST_IDLE;
        end

        default: begin
          capture_mask <= 4'b0000;
          r_state      <= ST_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Stale timeout
  // --------------------------------------------------------------------------
  logic [c_to_w-1:0] r_to_cnt;
  logic [c_to_w-1:0] w_to_next;

  assign w_to_next = (r_to_cnt == c_to_max) ? r_to_cnt : r_to_cnt + 1'b1;

  // A good frame landing on the threshold cycle takes priority, so stale
  // never blips high on that cycle.
  always_ff @(posedge clock_100Mhz) begin
    if (reset) begin
      r_to_cnt <= '0;
      stale    <= 1'b0;
    end else if (w_good_frame) begin
      r_to_cnt <= '0;
      stale    <= 1'b0;
    end else begin
      r_to_cnt <= w_to_next;
      stale    <= (w_to_next >= c_to_max);
    end
  end

endmodule : seven_segment_scan_decoder
`default_nettype wire

// File: tb/tb_seven_segment_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_seven_segment_scan_decoder
// Purpose  : Directed self-checking bench for seven_segment_scan_decoder
//            with SETTLE_CYCLES=4 and TIMEOUT_CYCLES=64.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seven_segment_scan_decoder;

  logic        clock_100Mhz = 1'b0;
  logic        reset;
  logic [3:0]  anode_in;
  logic [6:0]  cathode_in;
  logic [15:0] digits_out;
  logic [13:0] binary_out;
  logic        frame_valid;
  logic        error_flag;
  logic        stale;
  logic [3:0]  capture_mask;

  int tests_run    = 0;
  int tests_failed = 0;
  int fv_seen      = 0;
  int err_seen     = 0;

  seven_segment_scan_decoder #(
    .SETTLE_CYCLES  (4),
    .TIMEOUT_CYCLES (64)
  ) dut (
    .clock_100Mhz (clock_100Mhz),
    .reset        (reset),
    .anode_in     (anode_in),
    .cathode_in   (cathode_in),
    .digits_out   (digits_out),
    .binary_out   (binary_out),
    .frame_valid  (frame_valid),
    .error_flag   (error_flag),
    .stale        (stale),
    .capture_mask (capture_mask)
  );

  always #5 clock_100Mhz = ~clock_100Mhz;

  // Pulse counters, sampled mid-cycle.
  always @(negedge clock_100Mhz) begin
    if (frame_valid) fv_seen++;
    if (error_flag)  err_seen++;
  end

  function automatic logic [6:0] seg(input int d);
    case (d)
      0: return 7'b0000001;
      1: return 7'b1001111;
      2: return 7'b0010010;
      3: return 7'b0000110;
      4: return 7'b1001100;
      5: return 7'b0100100;
      6: return 7'b0100000;
      7: return 7'b0001111;
      8: return 7'b0000000;
      9: return 7'b0000100;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [3:0] an(input int i);
    case (i)
      0: return 4'b0111;
      1: return 4'b1011;
      2: return 4'b1101;
      3: return 4'b1110;
      default: return 4'b1111;
    endcase
  endfunction

  // Apply inputs at the falling edge, hold for n rising edges, then return
  // 1 ns after the last rising edge as the sample point.
  task automatic hold(input logic [3:0] a, input logic [6:0] c, input int n);
    @(negedge clock_100Mhz);
    anode_in   = a;
    cathode_in = c;
    repeat (n) @(posedge clock_100Mhz);
    #1;
  endtask

  task automatic scan_frame(input int d0, input int d1, input int d2, input int d3);
    hold(an(0), seg(d0), 8);
    hold(an(1), seg(d1), 8);
    hold(an(2), seg(d2), 8);
    hold(an(3), seg(d3), 8);
  endtask

  task automatic test_reset;
    reset = 1'b1; anode_in = 4'b1111; cathode_in = 7'h7F;
    repeat (3) @(posedge clock_100Mhz);
    #1;
    tests_run++; if (digits_out !== 16'h0000) begin tests_failed++; $display("FAIL reset_digits: got %h want 0000", digits_out); end
    tests_run++; if (binary_out !== 14'd0) begin tests_failed++; $display("FAIL reset_binary: got %0d want 0", binary_out); end
    tests_run++; if ({frame_valid, error_flag, stale} !== 3'b000) begin tests_failed++; $display("FAIL reset_flags: got %b want 000", {frame_valid, error_flag, stale}); end
    tests_run++; if (capture_mask !== 4'b0000) begin tests_failed++; $display("FAIL reset_mask: got %b want 0000", capture_mask); end
    @(negedge clock_100Mhz);
    reset = 1'b0;
  endtask

  task automatic test_basic_frame;
    int f0;
    f0 = fv_seen;
    hold(an(0), seg(1), 8);
    tests_run++; if (capture_mask !== 4'b0001) begin tests_failed++; $display("FAIL mask_d0: got %b want 0001", capture_mask); end
    hold(an(1), seg(2), 8);
    hold(an(2), seg(3), 8);
    tests_run++; if (capture_mask !== 4'b0111) begin tests_failed++; $display("FAIL mask_d2: got %b want 0111", capture_mask); end
    hold(an(3), seg(4), 4);
    tests_run++; if (frame_valid !== 1'b0) begin tests_failed++; $display("FAIL fv_at_T: got %b want 0", frame_valid); end
    hold(an(3), seg(4), 1);
    tests_run++; if (frame_valid !== 1'b1) begin tests_failed++; $display("FAIL fv_at_T1: got %b want 1", frame_valid); end
    tests_run++; if (digits_out !== 16'h1234) begin tests_failed++; $display("FAIL digits_1234: got %h want 1234", digits_out); end
    tests_run++; if (binary_out !== 14'd1234) begin tests_failed++; $display("FAIL binary_1234: got %0d want 1234", binary_out); end
    hold(an(3), seg(4), 3);
    tests_run++; if (frame_valid !== 1'b0 || capture_mask !== 4'b0000) begin tests_failed++; $display("FAIL after_done: fv=%b mask=%b want 0 0000", frame_valid, capture_mask); end
    tests_run++; if (fv_seen - f0 !== 1) begin tests_failed++; $display("FAIL fv_count_1234: got %0d want 1", fv_seen - f0); end
    scan_frame(9, 0, 5, 0);
    tests_run++; if (digits_out !== 16'h9050 || binary_out !== 14'd9050) begin tests_failed++; $display("FAIL frame_9050: got %h/%0d want 9050/9050", digits_out, binary_out); end
  endtask

  task automatic test_back_to_back;
    int f0;
    f0 = fv_seen;
    scan_frame(9, 9, 9, 9);
    scan_frame(9, 9, 9, 9);
    tests_run++; if (digits_out !== 16'h9999 || binary_out !== 14'd9999) begin tests_failed++; $display("FAIL frame_9999: got %h/%0d want 9999/9999", digits_out, binary_out); end
    tests_run++; if (fv_seen - f0 !== 2) begin tests_failed++; $display("FAIL repeat_fv: got %0d want 2", fv_seen - f0); end
  endtask

  task automatic test_bad_segment;
    int f0, e0;
    scan_frame(1, 2, 3, 4);
    f0 = fv_seen; e0 = err_seen;
    hold(an(0), seg(1), 8);
    hold(an(1), seg(2), 8);
    hold(an(2), 7'b1111111, 8);
    hold(an(3), seg(4), 4);
    tests_run++; if (error_flag !== 1'b0) begin tests_failed++; $display("FAIL bad_err_T: got %b want 0", error_flag); end
    hold(an(3), seg(4), 1);
    tests_run++; if (error_flag !== 1'b1 || frame_valid !== 1'b0) begin tests_failed++; $display("FAIL bad_err_T1: err=%b fv=%b want 1 0", error_flag, frame_valid); end
    hold(an(3), seg(4), 3);
    tests_run++; if (digits_out !== 16'h1234 || binary_out !== 14'd1234) begin tests_failed++; $display("FAIL bad_hold: got %h/%0d want 1234/1234", digits_out, binary_out); end
    tests_run++; if (fv_seen !== f0 || err_seen - e0 !== 1) begin tests_failed++; $display("FAIL bad_counts: fv+%0d err+%0d want 0 1", fv_seen - f0, err_seen - e0); end
  endtask

  task automatic test_glitch;
    int f0, e0;
    f0 = fv_seen; e0 = err_seen;
    hold(an(0), seg(8), 8);
    hold(an(1), seg(5), 2);
    hold(an(1), 7'b0100101, 1);
    hold(an(1), seg(5), 4);
    tests_run++; if (capture_mask !== 4'b0001) begin tests_failed++; $display("FAIL glitch_early: got %b want 0001", capture_mask); end
    hold(an(1), seg(5), 2);
    tests_run++; if (capture_mask !== 4'b0011) begin tests_failed++; $display("FAIL glitch_capture: got %b want 0011", capture_mask); end
    hold(an(2), seg(6), 8);
    hold(an(3), seg(7), 8);
    tests_run++; if (fv_seen - f0 !== 1 || err_seen !== e0) begin tests_failed++; $display("FAIL glitch_counts: fv+%0d err+%0d want 1 0", fv_seen - f0, err_seen - e0); end
    tests_run++; if (digits_out !== 16'h8567 || binary_out !== 14'd8567) begin tests_failed++; $display("FAIL glitch_frame: got %h/%0d want 8567/8567", digits_out, binary_out); end
  endtask

  task automatic test_anode_errors;
    int f0;
    hold(an(0), seg(1), 8);
    hold(an(2), seg(3), 5);
    tests_run++; if (error_flag !== 1'b1 || capture_mask !== 4'b0000) begin tests_failed++; $display("FAIL skip_idx: err=%b mask=%b want 1 0000", error_flag, capture_mask); end
    hold(an(2), seg(3), 3);
    hold(an(0), seg(1), 8);
    hold(4'b1001, seg(2), 5);
    tests_run++; if (error_flag !== 1'b1 || capture_mask !== 4'b0000) begin tests_failed++; $display("FAIL multi_anode: err=%b mask=%b want 1 0000", error_flag, capture_mask); end
    hold(4'b1001, seg(2), 3);
    f0 = fv_seen;
    hold(an(0), seg(1), 8);
    hold(an(1), seg(2), 8);
    hold(an(0), seg(6), 5);
    tests_run++; if (error_flag !== 1'b1) begin tests_failed++; $display("FAIL restart_err: got %b want 1", error_flag); end
    hold(an(0), seg(6), 3);
    hold(an(1), seg(7), 8);
    hold(an(2), seg(8), 8);
    hold(an(3), seg(9), 8);
    tests_run++; if (fv_seen - f0 !== 1 || digits_out !== 16'h6789 || binary_out !== 14'd6789) begin tests_failed++; $display("FAIL restart_frame: fv+%0d got %h/%0d want 1 6789/6789", fv_seen - f0, digits_out, binary_out); end
  endtask

  task automatic test_stale;
    hold(4'b1111, 7'h7F, 70);
    tests_run++; if (stale !== 1'b1) begin tests_failed++; $display("FAIL stale_set: got %b want 1", stale); end
    hold(an(0), seg(4), 8);
    hold(an(1), seg(3), 8);
    hold(an(2), seg(2), 8);
    hold(an(3), seg(1), 4);
    tests_run++; if (stale !== 1'b1) begin tests_failed++; $display("FAIL stale_pre_frame: got %b want 1", stale); end
    hold(an(3), seg(1), 1);
    tests_run++; if (frame_valid !== 1'b1 || digits_out !== 16'h4321 || binary_out !== 14'd4321) begin tests_failed++; $display("FAIL stale_frame: fv=%b got %h/%0d want 1 4321/4321", frame_valid, digits_out, binary_out); end
    hold(an(3), seg(1), 1);
    tests_run++; if (stale !== 1'b0) begin tests_failed++; $display("FAIL stale_clear: got %b want 0", stale); end
    hold(4'b1111, 7'h7F, 62);
    tests_run++; if (stale !== 1'b0) begin tests_failed++; $display("FAIL stale_63: got %b want 0", stale); end
    hold(4'b1111, 7'h7F, 1);
    tests_run++; if (stale !== 1'b1) begin tests_failed++; $display("FAIL stale_64: got %b want 1", stale); end
  endtask

  task automatic test_reset_midframe;
    int f0, e0;
    hold(an(0), seg(1), 8);
    hold(an(1), seg(2), 5);
    tests_run++; if (capture_mask !== 4'b0011) begin tests_failed++; $display("FAIL mid_mask: got %b want 0011", capture_mask); end
    @(negedge clock_100Mhz);
    reset = 1'b1;
    @(posedge clock_100Mhz);
    #1;
    tests_run++; if (capture_mask !== 4'b0000 || digits_out !== 16'h0000 || binary_out !== 14'd0) begin tests_failed++; $display("FAIL mid_reset_data: mask=%b got %h/%0d want 0000 0000/0", capture_mask, digits_out, binary_out); end
    tests_run++; if ({frame_valid, error_flag, stale} !== 3'b000) begin tests_failed++; $display("FAIL mid_reset_flags: got %b want 000", {frame_valid, error_flag, stale}); end
    @(negedge clock_100Mhz);
    reset = 1'b0;
    f0 = fv_seen; e0 = err_seen;
    hold(an(1), seg(2), 2);
    hold(an(2), seg(3), 8);
    hold(an(3), seg(4), 8);
    tests_run++; if (fv_seen !== f0 || err_seen !== e0 || digits_out !== 16'h0000) begin tests_failed++; $display("FAIL mid_no_frame: fv+%0d err+%0d digits=%h want 0 0 0000", fv_seen - f0, err_seen - e0, digits_out); end
  endtask

  initial begin
    reset      = 1'b1;
    anode_in   = 4'b1111;
    cathode_in = 7'h7F;
    test_reset();
    test_basic_frame();
    test_back_to_back();
    test_bad_segment();
    test_glitch();
    test_anode_errors();
    test_stale();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_seven_segment_scan_decoder
`default_nettype wire
